// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : apb_mem_slave
// APB3 completer over a word-addressed register array; fixed wait states, PSLVERR on bad address.
// Rev    : 1.0
// ============================================================================
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                    c_lsb        = $clog2(DATA_WIDTH / 8);
  localparam int                    c_idx_w      = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ADDR_WIDTH'((1 << c_lsb) - 1);
  localparam logic [3:0]            c_wait       = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_idx_w-1:0]    r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic                  w_setup;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic                  w_err;
  logic [c_idx_w-1:0]    w_idx;

  assign w_setup        = PSEL & ~PENABLE;
  assign w_misaligned   = |(PADDR & c_align_mask);
  // Any set bit above the index field means index >= DEPTH (DEPTH is a power of two).
  assign w_out_of_range = |(PADDR >> (c_lsb + c_idx_w));
  assign w_err          = w_misaligned | w_out_of_range;
  assign w_idx          = PADDR[c_lsb +: c_idx_w];

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_err   <= w_err;
            if (WAIT_CYCLES == 0) begin
              r_state   <= ST_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              if (!PWRITE) begin
                r_prdata <= w_err ? '0 : r_mem[w_idx];
              end
            end else begin
              r_cnt   <= c_wait;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (!PSEL) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state   <= ST_RESP;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            if (!r_write) begin
              r_prdata <= r_err ? '0 : r_mem[r_idx];
            end
          end
        end
        ST_RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
          if (r_write && !r_err) begin
            r_mem[r_idx] <= r_wdata;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module : tb_apb_mem_slave
// Self-checking bench for apb_mem_slave: three configurations sharing one APB driver.
// Rev    : 1.0
// ============================================================================
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata0;
  logic [7:0]  prdata1;
  logic [7:0]  prdata2;
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_setup_cyc;
  int last_done_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst 0: 32-bit, 16 words, 2 waits
  apb_mem_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) u_dut0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  // inst 1: 8-bit, 256 words, zero wait
  apb_mem_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[7:0]), .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  // inst 2: 8-bit, 256 words, 3 waits
  apb_mem_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(3)) u_dut2 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[7:0]), .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          err;
    bit          is_rd;
    logic [31:0] rdata;
    int          waits;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] get_rdata(input int inst);
    case (inst)
      0:       return prdata0;
      1:       return {24'd0, prdata1};
      default: return {24'd0, prdata2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; expectation queued at setup, popped when PREADY is seen.
  task automatic xfer(input int inst, input bit wr, input logic [12:0] addr,
                      input logic [31:0] wdata, input bit exp_err,
                      input logic [31:0] exp_rdata, input int exp_waits, input string name);
    exp_t e;
    exp_t got;
    int   n;
    e.err = exp_err; e.is_rd = !wr; e.rdata = exp_rdata; e.waits = exp_waits; e.name = name;
    @(negedge clk);
    psel = '0; psel[inst] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    last_setup_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    paddr   = ~addr;     // access-phase changes must be ignored
    pwdata  = ~wdata;
    n = 0;
    while (!pready[inst] && n < 20) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    if (!pready[inst]) begin
      check({got.name, "_timeout"}, 32'(pready[inst]), 32'd1);
    end else begin
      last_done_cyc = cyc;
      check({got.name, "_waits"}, 32'(n), 32'(got.waits));
      check({got.name, "_pslverr"}, 32'(pslverr[inst]), 32'(got.err));
      if (got.is_rd) check({got.name, "_prdata"}, get_rdata(inst), got.rdata);
    end
    psel = '0; penable = 1'b0;
  endtask

  vec_t        vecs[13];
  logic [31:0] model[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s;
    int seen;
    vecs[0]  = '{1'b1, 13'h008, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 13'h008, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 13'h006, 32'h12345678, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 13'h004, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b0, 13'h040, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 13'h040, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 13'h000, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b1, 13'h03C, 32'h11223344, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 13'h03C, 32'h0,        1'b0, 32'h11223344};
    vecs[9]  = '{1'b0, 13'h002, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 13'h1000, 32'h99999999, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 13'h000, 32'h0BADF00D, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 13'h000, 32'h0,        1'b0, 32'h0BADF00D};
    for (int i = 0; i < 16; i++) model[i] = '0;

    presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_pready%0d", k), 32'(pready[k]), 32'd0);
      check($sformatf("rst_pslverr%0d", k), 32'(pslverr[k]), 32'd0);
      check($sformatf("rst_prdata%0d", k), get_rdata(k), 32'd0);
    end
    presetn = 1'b1;

    // Table vectors on the 32-bit, 2-wait instance
    for (int i = 0; i < 13; i++) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
           vecs[i].exp_rdata, 2, $sformatf("vec%0d", i));
      if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr[5:2]] = vecs[i].wdata;
    end
    // Error writes must have left every word alone
    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, 13'(i * 4), 32'h0, 1'b0, model[i], 2, $sformatf("sweep%0d", i));

    // Zero-wait back-to-back on the 8-bit instance
    xfer(1, 1'b1, 13'h003, 32'h000000A5, 1'b0, 32'h0, 0, "zw_wr");
    s = last_setup_cyc;
    xfer(1, 1'b0, 13'h003, 32'h0, 1'b0, 32'h000000A5, 0, "zw_rd");
    check("b2b_cycles", 32'(last_done_cyc - s + 1), 32'd4);
    xfer(1, 1'b0, 13'h100, 32'h0, 1'b1, 32'h0, 0, "zw_oor");

    // Master abort in the 2nd access cycle of a 3-wait write
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 13'h000; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = '0; penable = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (pready[2]) seen = 1;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    xfer(2, 1'b0, 13'h000, 32'h0, 1'b0, 32'h0, 3, "abort_rd");

    // Reset during ST_WAIT of a write; PRDATA is non-zero beforehand
    xfer(0, 1'b0, 13'h008, 32'h0, 1'b0, 32'hDEADBEEF, 2, "pre_rst_rd");
    @(negedge clk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 13'h004; pwdata = 32'h77777777;
    @(negedge clk);
    penable = 1'b1; presetn = 1'b0; psel = '0;
    @(negedge clk);
    check("midrst_pready", 32'(pready[0]), 32'd0);
    check("midrst_pslverr", 32'(pslverr[0]), 32'd0);
    check("midrst_prdata", prdata0, 32'd0);
    presetn = 1'b1; penable = 1'b0;
    xfer(0, 1'b0, 13'h004, 32'h0, 1'b0, 32'h0, 2, "post_rst_rd4");
    xfer(0, 1'b0, 13'h008, 32'h0, 1'b0, 32'h0, 2, "post_rst_rd8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
